// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS control FSM.
// Holds opcode constants, the alu_op / alu_src_b / pc_source encodings,
// the FSM state enum, instruction classes, and the bundled control word
// that the FSM produces each cycle.
package mc_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_FUNCT = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_IALU    = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_t;

  typedef enum logic [1:0] {
    BR_EQ  = 2'd0,
    BR_NE  = 2'd1,
    BR_GTZ = 2'd2
  } br_kind_t;

  // Every datapath control produced in one cycle.
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundle between the control FSM and the datapath.
//   Datapath -> control: opcode, mem_ready, alu_zero, alu_sign.
//   Control -> datapath: every enable and mux select, plus dbg_state.
// Memory handshake: mem_read / mem_write is a request held with a stable
// iord until the cycle mem_ready=1; that cycle completes the access.
// mem_ready is only looked at while a request is outstanding.
// modport master = controller, modport slave = datapath.
interface multicycle_ctrl_if;
  import mc_ctrl_pkg::*;

  logic [5:0] opcode;
  logic       mem_ready;
  logic       alu_zero;
  logic       alu_sign;

  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [3:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  state_t     dbg_state;

  modport master (
    input  opcode, mem_ready, alu_zero, alu_sign,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, imm_zext, alu_op,
           pc_source, instr_done, illegal_op, dbg_state
  );

  modport slave (
    output opcode, mem_ready, alu_zero, alu_sign,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, imm_zext, alu_op,
           pc_source, instr_done, illegal_op, dbg_state
  );
endinterface

// File: rtl/mc_opcode_decode.sv
// mc_opcode_decode: combinational opcode classifier.
//   opcode   in  IR[31:26]
//   iclass   out instruction class (R-type, I-ALU, load, store, branch, jump, illegal)
//   i_alu_op out ALU operation for I-type ALU instructions
//   imm_zext out immediate is zero-extended (andi/ori)
//   br_kind  out branch condition kind (beq/bne/bgtz)
module mc_opcode_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  output instr_class_t iclass,
  output logic [3:0]   i_alu_op,
  output logic         imm_zext,
  output br_kind_t     br_kind
);

  always_comb begin
    iclass   = CLS_ILLEGAL;
    i_alu_op = ALU_ADD;
    imm_zext = 1'b0;
    br_kind  = BR_EQ;
    case (opcode)
      OP_RTYPE: iclass = CLS_RTYPE;
      OP_ADDI:  iclass = CLS_IALU;
      OP_ORI: begin
        iclass   = CLS_IALU;
        i_alu_op = ALU_OR;
        imm_zext = 1'b1;
      end
      OP_ANDI: begin
        iclass   = CLS_IALU;
        i_alu_op = ALU_AND;
        imm_zext = 1'b1;
      end
      OP_SLTI: begin
        iclass   = CLS_IALU;
        i_alu_op = ALU_SLT;
      end
      OP_LW:   iclass = CLS_LOAD;
      OP_SW:   iclass = CLS_STORE;
      OP_BEQ:  iclass = CLS_BRANCH;
      OP_BNE: begin
        iclass  = CLS_BRANCH;
        br_kind = BR_NE;
      end
      OP_BGTZ: begin
        iclass  = CLS_BRANCH;
        br_kind = BR_GTZ;
      end
      OP_J:    iclass = CLS_JUMP;
      default: iclass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for a shared MIPS datapath.
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset
//   bus    master side of multicycle_ctrl_if (opcode/flags/mem_ready in,
//          all datapath enables and selects plus dbg_state out)
// Sequences FETCH/DECODE then per-class states, stalls on mem_ready in
// FETCH/MEMRD/MEMWR, and pulses illegal_op for unsupported opcodes.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  state_t       state, state_nxt;
  logic         is_rtype;
  instr_class_t iclass;
  logic [3:0]   i_alu_op;
  logic         imm_zext;
  br_kind_t     br_kind;
  ctrl_t        ctrl, ctrl_out;

  mc_opcode_decode u_decode (
    .opcode   (bus.opcode),
    .iclass   (iclass),
    .i_alu_op (i_alu_op),
    .imm_zext (imm_zext),
    .br_kind  (br_kind)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      is_rtype <= 1'b0;
    end else begin
      state <= state_nxt;
      // Remember the class at decode so ALUWB can pick rd vs rt.
      if (state == S_DECODE) is_rtype <= (iclass == CLS_RTYPE);
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_BRANCH;
        ctrl.alu_op    = ALU_ADD;
        case (iclass)
          CLS_RTYPE:  state_nxt = S_EXEC_R;
          CLS_IALU:   state_nxt = S_EXEC_I;
          CLS_LOAD:   state_nxt = S_MEMADR;
          CLS_STORE:  state_nxt = S_MEMADR;
          CLS_BRANCH: state_nxt = S_BRANCH;
          CLS_JUMP:   state_nxt = S_JUMP;
          default:    state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_nxt      = (iclass == CLS_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (bus.mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (bus.mem_ready) begin
          ctrl.instr_done = 1'b1;
          state_nxt       = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
        state_nxt      = S_ALUWB;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = i_alu_op;
        ctrl.imm_zext  = imm_zext;
        state_nxt      = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_dst    = is_rtype;
        ctrl.instr_done = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
        // Flags come from rs-rt this cycle; bgtz has rt=$0 so the flags
        // describe rs itself.
        case (br_kind)
          BR_EQ:   ctrl.pc_write = bus.alu_zero;
          BR_NE:   ctrl.pc_write = !bus.alu_zero;
          BR_GTZ:  ctrl.pc_write = !bus.alu_zero && !bus.alu_sign;
          default: ctrl.pc_write = 1'b0;
        endcase
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_TRAP: begin
        // PC was already advanced in FETCH; just flag and move on.
        ctrl.illegal_op = 1'b1;
        state_nxt       = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, so an instruction
  // caught mid-flight cannot issue a request during the reset cycle.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign bus.pc_write   = ctrl_out.pc_write;
  assign bus.iord       = ctrl_out.iord;
  assign bus.mem_read   = ctrl_out.mem_read;
  assign bus.mem_write  = ctrl_out.mem_write;
  assign bus.ir_write   = ctrl_out.ir_write;
  assign bus.reg_dst    = ctrl_out.reg_dst;
  assign bus.mem_to_reg = ctrl_out.mem_to_reg;
  assign bus.reg_write  = ctrl_out.reg_write;
  assign bus.alu_src_a  = ctrl_out.alu_src_a;
  assign bus.alu_src_b  = ctrl_out.alu_src_b;
  assign bus.imm_zext   = ctrl_out.imm_zext;
  assign bus.alu_op     = ctrl_out.alu_op;
  assign bus.pc_source  = ctrl_out.pc_source;
  assign bus.instr_done = ctrl_out.instr_done;
  assign bus.illegal_op = ctrl_out.illegal_op;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle check of multicycle_ctrl.
// Each record gives the inputs for one cycle and the full expected output
// word (state + every control). Expected words are queued when a cycle is
// driven and popped when outputs are sampled on the falling edge.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Opcodes and ALU codes written out literally.
  localparam logic [5:0] C_R    = 6'b000000;
  localparam logic [5:0] C_ADDI = 6'b001000;
  localparam logic [5:0] C_ORI  = 6'b001101;
  localparam logic [5:0] C_ANDI = 6'b001100;
  localparam logic [5:0] C_SLTI = 6'b001010;
  localparam logic [5:0] C_LW   = 6'b100011;
  localparam logic [5:0] C_SW   = 6'b101011;
  localparam logic [5:0] C_BEQ  = 6'b000100;
  localparam logic [5:0] C_BNE  = 6'b000101;
  localparam logic [5:0] C_BGTZ = 6'b000111;
  localparam logic [5:0] C_J    = 6'b000010;
  localparam logic [5:0] C_BAD  = 6'b111111;
  localparam logic [5:0] C_BAD2 = 6'b000001;

  localparam logic [3:0] A_ADD   = 4'b0000;
  localparam logic [3:0] A_FUNCT = 4'b0001;
  localparam logic [3:0] A_SUB   = 4'b0010;
  localparam logic [3:0] A_AND   = 4'b0011;
  localparam logic [3:0] A_OR    = 4'b0100;
  localparam logic [3:0] A_SLT   = 4'b0101;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } obs_t;

  typedef struct {
    logic [5:0] opcode;
    logic       rdy;
    logic       z;
    logic       s;
    obs_t       exp;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // ---------------- expected output words ----------------
  function automatic obs_t e_blank(input state_t st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic obs_t e_fetch(input logic rdy);
    obs_t o = e_blank(S_FETCH);
    o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = A_ADD;
    o.ir_write = rdy;  o.pc_write = rdy;
    return o;
  endfunction

  function automatic obs_t e_decode();
    obs_t o = e_blank(S_DECODE);
    o.alu_src_b = 2'b11; o.alu_op = A_ADD;
    return o;
  endfunction

  function automatic obs_t e_memadr();
    obs_t o = e_blank(S_MEMADR);
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = A_ADD;
    return o;
  endfunction

  function automatic obs_t e_memrd();
    obs_t o = e_blank(S_MEMRD);
    o.mem_read = 1'b1; o.iord = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_memwb();
    obs_t o = e_blank(S_MEMWB);
    o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_memwr(input logic rdy);
    obs_t o = e_blank(S_MEMWR);
    o.mem_write = 1'b1; o.iord = 1'b1; o.instr_done = rdy;
    return o;
  endfunction

  function automatic obs_t e_exec_r();
    obs_t o = e_blank(S_EXEC_R);
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_op = A_FUNCT;
    return o;
  endfunction

  function automatic obs_t e_exec_i(input logic [3:0] op, input logic zx);
    obs_t o = e_blank(S_EXEC_I);
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = op; o.imm_zext = zx;
    return o;
  endfunction

  function automatic obs_t e_aluwb(input logic rd);
    obs_t o = e_blank(S_ALUWB);
    o.reg_write = 1'b1; o.reg_dst = rd; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_branch(input logic taken);
    obs_t o = e_blank(S_BRANCH);
    o.alu_src_a = 1'b1; o.alu_src_b = 2'b00; o.alu_op = A_SUB;
    o.pc_source = 2'b01; o.pc_write = taken; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_jump();
    obs_t o = e_blank(S_JUMP);
    o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_trap();
    obs_t o = e_blank(S_TRAP);
    o.illegal_op = 1'b1;
    return o;
  endfunction

  function automatic void add_vec(input logic [5:0] op, input logic rdy,
                                  input logic z, input logic s, input obs_t e);
    vecs.push_back('{op, rdy, z, s, e});
  endfunction

  // ---------------- driver + scoreboard ----------------
  function automatic obs_t sample();
    obs_t o;
    o.st         = bus.dbg_state;
    o.pc_write   = bus.pc_write;
    o.iord       = bus.iord;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.ir_write   = bus.ir_write;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.reg_write  = bus.reg_write;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.imm_zext   = bus.imm_zext;
    o.alu_op     = bus.alu_op;
    o.pc_source  = bus.pc_source;
    o.instr_done = bus.instr_done;
    o.illegal_op = bus.illegal_op;
    return o;
  endfunction

  // Drives one cycle (called just after a rising edge), checks on the
  // falling edge, then returns just after the next rising edge.
  task automatic apply(input logic r, input logic [5:0] op, input logic rdy,
                       input logic z, input logic s, input obs_t e,
                       input string tag);
    obs_t got, want;
    rst_n         = r;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.alu_zero  = z;
    bus.alu_sign  = s;
    exp_q.push_back(e);
    @(negedge clk);
    got  = sample();
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h (st=%0d) expected %h (st=%0d)",
               tag, got, got.st, want, want.st);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    int nwait;
    rst_n         = 1'b0;
    bus.opcode    = 6'b0;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    bus.alu_sign  = 1'b0;
    @(posedge clk);
    #1;
    apply(1'b0, 6'b0, 1'b1, 1'b0, 1'b0, e_blank(S_FETCH), "por_reset");

    // R-type, mem_ready low outside fetch must be ignored.
    add_vec(C_R, 1, 0, 0, e_fetch(1));
    add_vec(C_R, 0, 0, 0, e_decode());
    add_vec(C_R, 0, 0, 0, e_exec_r());
    add_vec(C_R, 0, 0, 0, e_aluwb(1));
    // addi with one fetch wait
    add_vec(C_ADDI, 0, 0, 0, e_fetch(0));
    add_vec(C_ADDI, 1, 0, 0, e_fetch(1));
    add_vec(C_ADDI, 1, 0, 0, e_decode());
    add_vec(C_ADDI, 1, 0, 0, e_exec_i(A_ADD, 0));
    add_vec(C_ADDI, 1, 0, 0, e_aluwb(0));
    // ori
    add_vec(C_ORI, 1, 0, 0, e_fetch(1));
    add_vec(C_ORI, 1, 0, 0, e_decode());
    add_vec(C_ORI, 1, 0, 0, e_exec_i(A_OR, 1));
    add_vec(C_ORI, 1, 0, 0, e_aluwb(0));
    // andi
    add_vec(C_ANDI, 1, 0, 0, e_fetch(1));
    add_vec(C_ANDI, 1, 0, 0, e_decode());
    add_vec(C_ANDI, 1, 0, 0, e_exec_i(A_AND, 1));
    add_vec(C_ANDI, 1, 0, 0, e_aluwb(0));
    // slti
    add_vec(C_SLTI, 1, 0, 0, e_fetch(1));
    add_vec(C_SLTI, 1, 0, 0, e_decode());
    add_vec(C_SLTI, 1, 0, 0, e_exec_i(A_SLT, 0));
    add_vec(C_SLTI, 1, 0, 0, e_aluwb(0));
    // sw zero-wait, then sw with one wait
    add_vec(C_SW, 1, 0, 0, e_fetch(1));
    add_vec(C_SW, 1, 0, 0, e_decode());
    add_vec(C_SW, 1, 0, 0, e_memadr());
    add_vec(C_SW, 1, 0, 0, e_memwr(1));
    add_vec(C_SW, 1, 0, 0, e_fetch(1));
    add_vec(C_SW, 1, 0, 0, e_decode());
    add_vec(C_SW, 1, 0, 0, e_memadr());
    add_vec(C_SW, 0, 0, 0, e_memwr(0));
    add_vec(C_SW, 1, 0, 0, e_memwr(1));
    // lw zero-wait
    add_vec(C_LW, 1, 0, 0, e_fetch(1));
    add_vec(C_LW, 1, 0, 0, e_decode());
    add_vec(C_LW, 1, 0, 0, e_memadr());
    add_vec(C_LW, 1, 0, 0, e_memrd());
    add_vec(C_LW, 1, 0, 0, e_memwb());
    // branches: {opcode, zero, sign, taken}
    add_vec(C_BEQ, 1, 0, 0, e_fetch(1));
    add_vec(C_BEQ, 1, 1, 0, e_decode());
    add_vec(C_BEQ, 1, 1, 0, e_branch(1));
    add_vec(C_BEQ, 1, 0, 0, e_fetch(1));
    add_vec(C_BEQ, 1, 0, 0, e_decode());
    add_vec(C_BEQ, 1, 0, 1, e_branch(0));
    add_vec(C_BNE, 1, 0, 0, e_fetch(1));
    add_vec(C_BNE, 1, 0, 0, e_decode());
    add_vec(C_BNE, 1, 1, 0, e_branch(0));
    add_vec(C_BNE, 1, 0, 0, e_fetch(1));
    add_vec(C_BNE, 1, 0, 0, e_decode());
    add_vec(C_BNE, 1, 0, 1, e_branch(1));
    add_vec(C_BGTZ, 1, 0, 0, e_fetch(1));
    add_vec(C_BGTZ, 1, 0, 0, e_decode());
    add_vec(C_BGTZ, 1, 0, 1, e_branch(0));
    add_vec(C_BGTZ, 1, 0, 0, e_fetch(1));
    add_vec(C_BGTZ, 1, 0, 0, e_decode());
    add_vec(C_BGTZ, 1, 0, 0, e_branch(1));
    add_vec(C_BGTZ, 1, 0, 0, e_fetch(1));
    add_vec(C_BGTZ, 1, 0, 0, e_decode());
    add_vec(C_BGTZ, 1, 1, 0, e_branch(0));
    // jump
    add_vec(C_J, 1, 0, 0, e_fetch(1));
    add_vec(C_J, 1, 0, 0, e_decode());
    add_vec(C_J, 1, 0, 0, e_jump());
    // illegal opcodes
    add_vec(C_BAD, 1, 0, 0, e_fetch(1));
    add_vec(C_BAD, 1, 1, 0, e_decode());
    add_vec(C_BAD, 1, 1, 0, e_trap());
    add_vec(C_BAD2, 1, 0, 0, e_fetch(1));
    add_vec(C_BAD2, 1, 0, 0, e_decode());
    add_vec(C_BAD2, 1, 0, 0, e_trap());
    // R-type after a non-R instruction: reg_dst must follow the new class
    add_vec(C_R, 1, 0, 0, e_fetch(1));
    add_vec(C_R, 1, 0, 0, e_decode());
    add_vec(C_R, 1, 0, 0, e_exec_r());
    add_vec(C_R, 1, 0, 0, e_aluwb(1));

    foreach (vecs[i])
      apply(1'b1, vecs[i].opcode, vecs[i].rdy, vecs[i].z, vecs[i].s,
            vecs[i].exp, $sformatf("vec%0d", i));

    // lw with two MEMRD wait cycles: 7 cycles, request stable throughout.
    apply(1, C_LW, 1, 0, 0, e_fetch(1), "lw7_fetch");
    apply(1, C_LW, 1, 0, 0, e_decode(), "lw7_decode");
    apply(1, C_LW, 1, 0, 0, e_memadr(), "lw7_memadr");
    apply(1, C_LW, 0, 0, 0, e_memrd(), "lw7_memrd0");
    apply(1, C_LW, 0, 0, 0, e_memrd(), "lw7_memrd1");
    apply(1, C_LW, 1, 0, 0, e_memrd(), "lw7_memrd2");
    apply(1, C_LW, 1, 0, 0, e_memwb(), "lw7_memwb");

    // Jump after a random number of fetch wait cycles.
    nwait = $urandom_range(1, 4);
    for (int k = 0; k < nwait; k++)
      apply(1, C_J, 0, 0, 0, e_fetch(0), $sformatf("jwait%0d", k));
    apply(1, C_J, 1, 0, 0, e_fetch(1), "jw_fetch");
    apply(1, C_J, 0, 0, 0, e_decode(), "jw_decode");
    apply(1, C_J, 0, 0, 0, e_jump(), "jw_jump");

    // Reset held 3 cycles while a store is stalled in MEMWR.
    apply(1, C_SW, 1, 0, 0, e_fetch(1), "rst_fetch");
    apply(1, C_SW, 1, 0, 0, e_decode(), "rst_decode");
    apply(1, C_SW, 1, 0, 0, e_memadr(), "rst_memadr");
    apply(1, C_SW, 0, 0, 0, e_memwr(0), "rst_memwr");
    apply(0, C_SW, 1, 1, 0, e_blank(S_MEMWR), "rst_cyc0");
    apply(0, C_SW, 1, 1, 0, e_blank(S_FETCH), "rst_cyc1");
    apply(0, C_SW, 1, 1, 0, e_blank(S_FETCH), "rst_cyc2");
    apply(1, C_J, 1, 0, 0, e_fetch(1), "rst_release_fetch");
    apply(1, C_J, 1, 0, 0, e_decode(), "rst_release_decode");
    apply(1, C_J, 1, 0, 0, e_jump(), "rst_release_jump");
    apply(1, C_R, 0, 0, 0, e_fetch(0), "final_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
